// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    modport master (
        output req, we, funct3, addr, wdata, mem_RD,
        input  busy, done, rdata, fault, mem_A, mem_WD, mem_WE
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_RD,
        output busy, done, rdata, fault, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write for byte/halfword stores
module load_store_unit #(
    parameter int DEPTH = 101
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_A;
    logic [31:0] r_mem_WD;
    logic        r_mem_WE;

    logic        w_fault;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Decode the incoming request; only meaningful in IDLE when req is high.
    always_comb begin
        w_fault = 1'b0;
        if (!bus.we && (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11))
            w_fault = 1'b1;
        if (bus.we && (bus.funct3[2] || bus.funct3[1:0] == 2'b11))
            w_fault = 1'b1;
        if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
            w_fault = 1'b1;
        if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
            w_fault = 1'b1;
        if ({2'b00, bus.addr[31:2]} >= DEPTH_W)
            w_fault = 1'b1;
    end

    always_comb begin
        w_byte = bus.mem_RD[{r_lane, 3'b000} +: 8];
        w_half = bus.mem_RD[{r_lane[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = bus.mem_RD;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the word just read.
    always_comb begin
        w_merge = bus.mem_RD;
        if (r_funct3[0])
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        else
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_funct3 <= 3'b000;
            r_lane   <= 2'b00;
            r_wdata  <= 16'h0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'h0;
            r_mem_A  <= 32'h0;
            r_mem_WD <= 32'h0;
            r_mem_WE <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_funct3 <= bus.funct3;
                        r_lane   <= bus.addr[1:0];
                        r_wdata  <= bus.wdata[15:0];
                        r_mem_A  <= {bus.addr[31:2], 2'b00};
                        r_busy   <= 1'b1;
                        if (w_fault) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else if (!bus.we) begin
                            r_state <= LOAD;
                        end else if (bus.funct3 == 3'b010) begin
                            r_state  <= STORE;
                            r_mem_WE <= 1'b1;
                            r_mem_WD <= bus.wdata;
                        end else begin
                            r_state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_rdata <= w_load;
                    r_state <= RESP;
                    r_done  <= 1'b1;
                end
                STORE: begin
                    r_mem_WE <= 1'b0;
                    r_state  <= RESP;
                    r_done   <= 1'b1;
                end
                RMW_RD: begin
                    r_mem_WD <= w_merge;
                    r_mem_WE <= 1'b1;
                    r_state  <= RMW_WR;
                end
                RMW_WR: begin
                    r_mem_WE <= 1'b0;
                    r_state  <= RESP;
                    r_done   <= 1'b1;
                end
                RESP: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_fault  <= 1'b0;
                    r_mem_WE <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.fault  = r_fault;
    assign bus.rdata  = r_rdata;
    assign bus.mem_A  = r_mem_A;
    assign bus.mem_WD = r_mem_WD;
    assign bus.mem_WE = r_mem_WE;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a word-array reference model
module tb_load_store_unit;
    localparam int DEPTH = 101;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          acc;
        int          lat;
        int          nwe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    logic [31:0] ref_rdata;
    logic [31:0] w_widx;
    exp_t        q[$];
    exp_t        m_e;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          we_seen = 0;

    assign w_widx = {2'b00, bus.mem_A[31:2]};
    always_comb bus.mem_RD = (w_widx < DEPTH) ? mem[w_widx[6:0]] : 32'h0;
    always @(posedge clk) if (bus.mem_WE && w_widx < DEPTH) mem[w_widx[6:0]] = bus.mem_WD;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit model_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = int'(f3) % 4;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (sz == 1 && a % 2 != 0) return 1'b1;
        if (sz == 2 && a % 4 != 0) return 1'b1;
        if (a / 4 >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Computes expected outcome from the access rules, updates the reference, then issues.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          t;
        int          sh;
        logic [31:0] w;
        logic [31:0] v;
        @(negedge clk);
        t = 0;
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            checks++;
            fails++;
            $display("FAIL idle_wait: busy stayed 1 for 50 cycles, required 0");
        end
        bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        e.fault = model_fault(we, f3, a);
        e.nwe = 0;
        if (e.fault) begin
            e.lat = 1;
        end else if (!we) begin
            w = ref_mem[a[8:2]];
            e.lat = 2;
            if (f3 == 3'd0 || f3 == 3'd4) begin
                sh = 8 * int'(a[1:0]);
                v = (w >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFFFF00;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                sh = 16 * int'(a[1]);
                v = (w >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            ref_rdata = v;
        end else if (f3 == 3'd2) begin
            ref_mem[a[8:2]] = wd;
            e.lat = 2;
            e.nwe = 1;
        end else begin
            w = ref_mem[a[8:2]];
            if (f3 == 3'd0) begin
                sh = 8 * int'(a[1:0]);
                w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end else begin
                sh = 16 * int'(a[1]);
                w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            ref_mem[a[8:2]] = w;
            e.lat = 3;
            e.nwe = 1;
        end
        e.rdata = ref_rdata;
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        bus.req = 1'b0;
        chk("busy_after_accept", {31'h0, bus.busy}, 32'h1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || bus.busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || bus.busy) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",   {31'h0, bus.busy},   32'h0);
        chk("rst_done",   {31'h0, bus.done},   32'h0);
        chk("rst_fault",  {31'h0, bus.fault},  32'h0);
        chk("rst_rdata",  bus.rdata,           32'h0);
        chk("rst_mem_WE", {31'h0, bus.mem_WE}, 32'h0);
        chk("rst_mem_A",  bus.mem_A,           32'h0);
        chk("rst_mem_WD", bus.mem_WD,          32'h0);
    endtask

    // Monitor: pops one expectation for every completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_WE) we_seen++;
            chk("fault_without_done", {31'h0, bus.fault & ~bus.done}, 32'h0);
            chk("mem_A_align", {30'h0, bus.mem_A[1:0]}, 32'h0);
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 with no request outstanding, required 0");
                end else begin
                    m_e = q.pop_front();
                    chk("resp_fault", {31'h0, bus.fault}, {31'h0, m_e.fault});
                    chk("resp_rdata", bus.rdata, m_e.rdata);
                    chk("resp_latency", 32'(cyc - m_e.acc + 1), 32'(m_e.lat));
                    chk("resp_we_count", 32'(we_seen), 32'(m_e.nwe));
                end
                we_seen = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] v;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        ref_rdata = 32'h0;

        rst = 1'b1;
        bus.req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        bus.req = 1'b0;
        rst = 1'b0;

        issue(1'b0, 3'd0, 32'h11, 32'h0);
        drain();
        chk("lb_sign", bus.rdata, 32'hFFFFFFAA);
        issue(1'b0, 3'd4, 32'h11, 32'h0);
        drain();
        chk("lbu_zero", bus.rdata, 32'h000000AA);
        issue(1'b1, 3'd0, 32'h12, 32'h55);
        drain();
        chk("sb_merge", mem[4], 32'h8855AABB);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        drain();
        chk("lw_after_sb", bus.rdata, 32'h8855AABB);
        issue(1'b0, 3'd1, 32'h13, 32'h0);
        drain();
        chk("lh_misaligned_rdata", bus.rdata, 32'h8855AABB);
        issue(1'b1, 3'd2, 32'(DEPTH * 4), 32'h12345678);
        drain();
        chk("sw_range_rdata", bus.rdata, 32'h8855AABB);

        begin
            exp_t e;
            @(negedge clk);
            bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h0; bus.wdata = 32'hDEADBEEF;
            e.fault = 1'b0; e.lat = 2; e.nwe = 1; e.rdata = ref_rdata;
            ref_mem[0] = 32'hDEADBEEF;
            @(posedge clk);
            #1;
            e.acc = cyc;
            q.push_back(e);
            @(posedge clk);
            @(posedge clk);
            @(posedge clk);
            #1;
            e.acc = cyc;
            q.push_back(e);
            bus.req = 1'b0;
            drain();
            chk("sw_held_mem", mem[0], 32'hDEADBEEF);
        end

        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'd1; bus.addr = 32'h6; bus.wdata = $urandom;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs();
        ref_rdata = 32'h0;
        repeat (6) @(negedge clk);
        chk("abort_no_we", 32'(we_seen), 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(DEPTH * 4) + $urandom_range(0, 7);
            else             a = $urandom_range(0, DEPTH * 4 - 1);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH, default 101, is the number of 32-bit words in the attached data memory.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port req  input  1  core access request; sampled only in IDLE.
REQ-005 Port we  input  1  1 = store, 0 = load; sampled with req.
REQ-006 Port funct3  input  3  RV32I width/sign code; sampled with req.
REQ-007 Port addr  input  32  byte address; sampled with req.
REQ-008 Port wdata  input  32  store data, LSB-aligned; sampled with req.
REQ-009 Port busy  output  1  high whenever state is not IDLE.
REQ-010 Port done  output  1  one-cycle completion pulse.
REQ-011 Port rdata  output  32  extended load result.
REQ-012 Port fault  output  1  access rejected; valid only while done=1.
REQ-013 Port mem_A  output  32  memory address, always word-aligned (bits [1:0]=0).
REQ-014 Port mem_WD  output  32  memory write word.
REQ-015 Port mem_WE  output  1  memory write enable.
REQ-016 Port mem_RD  input  32  memory read word, combinational from mem_A.

Function
REQ-017 States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-018 In IDLE with req=1: latch we, funct3, addr, wdata; req while busy=1 is ignored.
REQ-019 Fault on accept if any holds: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH.
REQ-020 Faulting request: IDLE -> RESP; no mem_WE; done=1 and fault=1 in the next cycle; rdata unchanged.
REQ-021 Valid load: IDLE -> LOAD -> RESP; in LOAD mem_A={addr[31:2],2'b00} and rdata is registered from mem_RD at LOAD's closing edge.
REQ-022 Load extraction: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-023 SW: IDLE -> STORE -> RESP; mem_WE=1 for exactly the STORE cycle with mem_WD=wdata.
REQ-024 SB/SH: IDLE -> RMW_RD -> RMW_WR -> RESP; RMW_RD registers mem_RD; RMW_WR drives mem_WE=1 with that word, selected lane replaced by wdata[7:0] or wdata[15:0], other bytes preserved.
REQ-025 Latency, accept edge to done: fault 1 cycle, load 2, SW 2, SB/SH 3.
REQ-026 RESP lasts one cycle (done=1), then IDLE; a req present in that cycle is ignored; next accept no earlier than the following cycle.
REQ-027 mem_WE is 0 in every state except STORE and RMW_WR.
REQ-028 mem_A holds the latched word address from accept until the next accept.
REQ-029 rdata changes only at LOAD completion and holds otherwise, including across stores and faults.
REQ-030 fault is 0 whenever done=0.

Reset
REQ-031 rst=1 at a rising edge forces IDLE, busy=0, done=0, fault=0, rdata=0, mem_WE=0, mem_A=0, mem_WD=0.
REQ-032 rst during STORE or RMW_RD aborts the access: no mem_WE after the reset edge, no done pulse for the aborted request.
REQ-033 req is ignored in any cycle where rst=1.

Verification
REQ-034 Memory word 4 = 0x8899AABB; LB addr 0x11 -> done 2 cycles after accept, rdata=0xFFFFFFAA; LBU -> 0x000000AA.
REQ-035 Word 4 = 0x8899AABB; SB addr 0x12 wdata 0x55 -> one mem_WE, WD=0x8855AABB, done 3 cycles after accept; LW addr 0x10 returns 0x8855AABB.
REQ-036 LH addr 0x13 -> done 1 cycle after accept with fault=1, no mem_WE, rdata unchanged; SW with addr[31:2]=DEPTH -> same fault response.
REQ-037 SW addr 0x0 wdata 0xDEADBEEF, req held high throughout -> exactly one mem_WE; second accept only after the RESP cycle.
REQ-038 SH addr 0x6, rst=1 in RMW_RD cycle -> mem_WE never asserts, done never pulses, all outputs at reset values next cycle.
